// File: rtl/weave_pkg.sv
// Shared widths, state encoding, request payload and the bit-weave function
// for the weave arbiter.
package weave_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PAT_W   = 3;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [PAT_W-1:0]  pat;
    } weave_req_t;

    // Shifting at DATA_W width drops the overflow bits, and the mask wraps to all-ones for pat=7.
    function automatic logic [DATA_W-1:0] weave(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [PAT_W-1:0]  pat
    );
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] mask;
        shifted = DATA_W'(a) << (32'(pat) + 32'd1);
        mask    = (DATA_W'(1) << (32'(pat) + 32'd1)) - DATA_W'(1);
        return shifted | (b & mask);
    endfunction

endpackage

// File: rtl/weave_arbiter_weave_unit.sv
// Purely combinational bit-weave of operands a and b under a 3-bit pattern.
module weave_unit
    import weave_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [PAT_W-1:0]  pat,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = weave(a, b, pat);
    end

endmodule

// File: rtl/weave_arbiter.sv
// Two-requester round-robin front-end for the weave unit with a registered output stage.
// Optional multi-beat sweep over all eight patterns is enabled by defining WEAVE_SWEEP_EN.
module weave_arbiter
    import weave_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*PAT_W-1:0]    req_pat,
    input  logic [NUM_REQ-1:0]          req_sweep,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [PAT_W-1:0]            out_pat,
    output logic                        out_src,
    output logic                        out_last,
    output logic                        busy
);

    state_t            state;
    logic              rr;
    logic              gnt;
    logic              accept;
    logic              take;
    weave_req_t        sel;
    logic [DATA_W-1:0] wu_a;
    logic [DATA_W-1:0] wu_b;
    logic [PAT_W-1:0]  wu_pat;
    logic [DATA_W-1:0] wu_data;

`ifdef WEAVE_SWEEP_EN
    logic [DATA_W-1:0] sw_a;
    logic [DATA_W-1:0] sw_b;
    logic [PAT_W-1:0]  cnt;
    logic              start_sweep;
`else
    logic              unused_sweep;
    assign unused_sweep = ^req_sweep;
`endif

    // Grant: a lone requester wins; on contention the round-robin pointer decides.
    always_comb begin
        gnt       = (&req_valid) ? rr : req_valid[1];
        accept    = (state == IDLE) || ((state == HOLD) && out_ready);
        take      = accept && (|req_valid);
        req_ready = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        sel.a     = gnt ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        sel.b     = gnt ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        sel.pat   = gnt ? req_pat[2*PAT_W-1:PAT_W] : req_pat[PAT_W-1:0];
    end

    // Weave operand mux: granted request, or latched sweep operands with the next pattern.
    always_comb begin
        wu_a   = sel.a;
        wu_b   = sel.b;
        wu_pat = sel.pat;
`ifdef WEAVE_SWEEP_EN
        start_sweep = take && req_sweep[gnt];
        if (state == SWEEP) begin
            wu_a   = sw_a;
            wu_b   = sw_b;
            wu_pat = PAT_W'(cnt + 3'd1);
        end else if (start_sweep) begin
            wu_pat = '0;
        end
`endif
    end

    weave_unit u_weave_unit (
        .a    (wu_a),
        .b    (wu_b),
        .pat  (wu_pat),
        .data (wu_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pat   <= '0;
            out_src   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef WEAVE_SWEEP_EN
            sw_a      <= '0;
            sw_b      <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (take) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_data  <= wu_data;
                        out_src   <= gnt;
                        rr        <= ~gnt;
`ifdef WEAVE_SWEEP_EN
                        if (start_sweep) begin
                            state    <= SWEEP;
                            out_pat  <= '0;
                            out_last <= 1'b0;
                            sw_a     <= sel.a;
                            sw_b     <= sel.b;
                            cnt      <= '0;
                        end else begin
                            state    <= HOLD;
                            out_pat  <= sel.pat;
                            out_last <= 1'b1;
                        end
`else
                        state    <= HOLD;
                        out_pat  <= sel.pat;
                        out_last <= 1'b1;
`endif
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
`ifdef WEAVE_SWEEP_EN
                // One beat per handshake; the pattern-7 handshake closes the sweep.
                SWEEP: begin
                    if (out_ready) begin
                        if (cnt == 3'd7) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt      <= PAT_W'(cnt + 3'd1);
                            out_data <= wu_data;
                            out_pat  <= wu_pat;
                            out_last <= (wu_pat == 3'd7);
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weave_arbiter.sv
// Directed self-checking bench for weave_arbiter; sweep steps run only when WEAVE_SWEEP_EN is defined.
module tb_weave_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [5:0]  req_pat;
    logic [1:0]  req_sweep;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_pat;
    logic        out_src;
    logic        out_last;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    weave_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_pat   (req_pat),
        .req_sweep (req_sweep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pat   (out_pat),
        .out_src   (out_src),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] sweep_aa [8];
        logic [7:0] sweep_81 [8];
        sweep_aa = '{8'h55, 8'hA9, 8'h55, 8'hA5, 8'h55, 8'h95, 8'h55, 8'h55};
        sweep_81 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};

        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; req_pat = '0;
        req_sweep = 2'b00; out_ready = 1'b1;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_pat",   32'(out_pat),   32'd0);
        chk("rst_src",   32'(out_src),   32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        step();

        // Single request from req0, pattern 3.
        req_a[7:0] = 8'hF0; req_b[7:0] = 8'h0F; req_pat[2:0] = 3'd3; req_valid = 2'b01;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(out_data),  32'h0F);
        chk("t1_pat",   32'(out_pat),   32'd3);
        chk("t1_src",   32'(out_src),   32'd0);
        chk("t1_last",  32'(out_last),  32'd1);
        chk("t1_busy",  32'(busy),      32'd1);
        step();
        chk("t1_drain_valid", 32'(out_valid), 32'd0);
        chk("t1_drain_busy",  32'(busy),      32'd0);

        // Reset pulse returns rr to 0 before the contention run.
        rst = 1'b1; #2; rst = 1'b0;
        step();

        // Both requesters continuously valid: strict alternation starting at req0.
        req_a = {8'h00, 8'hFF}; req_b = {8'hFF, 8'h00}; req_pat = {3'd7, 3'd0};
        req_valid = 2'b11;
        #1;
        chk("t2_ready0", 32'(req_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_src%0d", k),   32'(out_src),   32'(k % 2));
            chk($sformatf("t2_data%0d", k),  32'(out_data),  (k % 2 == 1) ? 32'hFF : 32'hFE);
            chk($sformatf("t2_pat%0d", k),   32'(out_pat),   (k % 2 == 1) ? 32'd7 : 32'd0);
            chk($sformatf("t2_ready%0d", k + 1), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
        end
        req_valid = 2'b00;
        step();
        chk("t2_idle", 32'(out_valid), 32'd0);

        // Back-pressure: req1 accepted, then stalled five cycles with both valid.
        out_ready = 1'b0; req_valid = 2'b10;
        #1;
        chk("t3_ready_idle", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t3_stall_ready%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("t3_stall_data%0d", k),  32'(out_data),  32'hFF);
            chk($sformatf("t3_stall_src%0d", k),   32'(out_src),   32'd1);
            chk($sformatf("t3_stall_valid%0d", k), 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_refill_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        chk("t3_refill_valid", 32'(out_valid), 32'd1);
        chk("t3_refill_data",  32'(out_data),  32'hFE);
        chk("t3_refill_src",   32'(out_src),   32'd0);
        step();
        chk("t3_empty", 32'(out_valid), 32'd0);

`ifdef WEAVE_SWEEP_EN
        // Sweep from req1 with A=AA, B=55; req0 stays valid to prove req_ready is held low.
        req_a = {8'hAA, 8'h33}; req_b = {8'h55, 8'h44}; req_pat = {3'd0, 3'd2};
        req_sweep = 2'b10; req_valid = 2'b10;
        #1;
        chk("sw1_ready_start", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b01; req_sweep = 2'b00;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("sw1_data%0d", k),  32'(out_data),  32'(sweep_aa[k]));
            chk($sformatf("sw1_pat%0d", k),   32'(out_pat),   32'(k));
            chk($sformatf("sw1_last%0d", k),  32'(out_last),  (k == 7) ? 32'd1 : 32'd0);
            chk($sformatf("sw1_src%0d", k),   32'(out_src),   32'd1);
            chk($sformatf("sw1_ready%0d", k), 32'(req_ready), 32'h0);
            if (k == 7) req_valid = 2'b00;
            step();
        end
        chk("sw1_end_valid", 32'(out_valid), 32'd0);
        chk("sw1_end_busy",  32'(busy),      32'd0);

        // Sweep from req0 with A=81, B=00; reset lands on the third beat.
        req_a = {8'h00, 8'h81}; req_b = {8'h00, 8'h00}; req_sweep = 2'b01; req_valid = 2'b01;
        step();
        req_valid = 2'b00; req_sweep = 2'b00;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sw2_data%0d", k), 32'(out_data), 32'(sweep_81[k]));
            chk($sformatf("sw2_pat%0d", k),  32'(out_pat),  32'(k));
            if (k < 2) step();
        end
`else
        // Leave a stalled req0 result pending so rr points at req1 before the reset.
        out_ready = 1'b0;
        req_a = {8'h00, 8'h81}; req_b = '0; req_pat = '0; req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("nosw_hold_valid", 32'(out_valid), 32'd1);
        chk("nosw_hold_data",  32'(out_data),  32'h02);
        chk("nosw_hold_last",  32'(out_last),  32'd1);
        out_ready = 1'b1;
`endif
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        step();
        rst = 1'b0;
        req_a = {8'h00, 8'hFF}; req_b = {8'hFF, 8'h00}; req_pat = {3'd7, 3'd0};
        req_valid = 2'b11;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        chk("post_rst_src",  32'(out_src),  32'd0);
        chk("post_rst_data", 32'(out_data), 32'hFE);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
